// File: rtl/fpadd_pkg.sv
// ============================================================================
// fpadd_pkg: constants shared by DataMemory, fpadd_pipelined and capture.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fpadd_pkg;

  localparam int FP_WORD_WIDTH   = 32;
  localparam int DEFAULT_LATENCY = 4;

  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_result_capture_pulse_delay_line.sv
// ============================================================================
// pulse_delay_line: LATENCY-deep one-bit shift register producing the strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_delay_line #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic pulse_out
);

  logic [LATENCY-1:0] tag;

  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) tag <= '0;
        else     tag <= pulse_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) tag <= '0;
        else     tag <= {tag[LATENCY-2:0], pulse_in};
      end
    end
  endgenerate

  assign pulse_out = tag[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/fp_result_capture.sv
// ============================================================================
// fp_result_capture: stores delayed adder results and steps through them.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_result_capture
  import fpadd_pkg::*;
#(
  parameter int LATENCY  = DEFAULT_LATENCY,
  parameter int DEPTH    = 8,
  parameter int FP_WIDTH = FP_WORD_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           capture_pulse,
  input  logic                           review_pulse,
  input  logic [FP_WIDTH-1:0]            result_in,
  output logic [FP_WIDTH-1:0]            disp_data,
  output logic [idx_width(DEPTH)-1:0]    rd_idx,
  output logic [idx_width(DEPTH):0]      count,
  output logic                           full,
  output logic                           overflow
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic                wr;
  logic                wr_en;
  logic                rev_en;
  logic [IDX_W-1:0]    next_idx;
  logic [FP_WIDTH-1:0] mem [DEPTH];

  pulse_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (capture_pulse),
    .pulse_out (wr)
  );

  assign full = (count == CNT_W'(DEPTH));

  // A strobe always wins over review, so review only acts in strobe-free cycles.
  always_comb begin
    wr_en    = wr && !full;
    rev_en   = review_pulse && !wr && (count != '0);
    next_idx = rd_idx + 1'b1;
    if ({1'b0, rd_idx} == count - 1'b1) next_idx = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[count[IDX_W-1:0]] <= result_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_data <= '0;
      rd_idx    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else if (wr) begin
      if (wr_en) begin
        count     <= count + 1'b1;
        rd_idx    <= count[IDX_W-1:0];
        disp_data <= result_in;
      end else begin
        overflow  <= 1'b1;
      end
    end else if (rev_en) begin
      rd_idx    <= next_idx;
      disp_data <= mem[next_idx];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_result_capture.sv
// ============================================================================
// tb_fp_result_capture: scoreboard bench for the result capture buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp_result_capture;

  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        capture_pulse = 1'b0;
  logic        review_pulse  = 1'b0;
  logic [31:0] result_in = '0;
  logic [31:0] disp_data;
  logic [2:0]  rd_idx;
  logic [3:0]  count;
  logic        full;
  logic        overflow;

  fp_result_capture #(
    .LATENCY  (LAT),
    .DEPTH    (DEPTH),
    .FP_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .capture_pulse (capture_pulse),
    .review_pulse  (review_pulse),
    .result_in     (result_in),
    .disp_data     (disp_data),
    .rd_idx        (rd_idx),
    .count         (count),
    .full          (full),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] v;
  } sched_t;

  typedef struct {
    int          due;
    logic [31:0] disp;
    logic [3:0]  cnt;
    logic [2:0]  rd;
    logic        full;
    logic        ovf;
  } exp_t;

  sched_t sq[$];
  exp_t   exq[$];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  // Reference state of the buffer as seen by the stimulus
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_disp;
  int          m_count;
  logic [2:0]  m_rd;
  logic        m_ovf;

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sq.size() > 0 && sq[0].due == cyc) begin
      result_in = sq[0].v;
      void'(sq.pop_front());
    end else begin
      result_in = $urandom;
    end
    if (exq.size() > 0 && exq[0].due == cyc) begin
      e = exq.pop_front();
      total++;
      if (disp_data !== e.disp) begin
        bad++; $display("FAIL sb_disp cyc=%0d got=%h exp=%h", cyc, disp_data, e.disp);
      end
      total++;
      if (count !== e.cnt) begin
        bad++; $display("FAIL sb_count cyc=%0d got=%0d exp=%0d", cyc, count, e.cnt);
      end
      total++;
      if (rd_idx !== e.rd) begin
        bad++; $display("FAIL sb_rd_idx cyc=%0d got=%0d exp=%0d", cyc, rd_idx, e.rd);
      end
      total++;
      if (full !== e.full) begin
        bad++; $display("FAIL sb_full cyc=%0d got=%b exp=%b", cyc, full, e.full);
      end
      total++;
      if (overflow !== e.ovf) begin
        bad++; $display("FAIL sb_overflow cyc=%0d got=%b exp=%b", cyc, overflow, e.ovf);
      end
    end
  endtask

  task automatic capture(input logic [31:0] v);
    sched_t s;
    exp_t   e;
    capture_pulse = 1'b1;
    s.due = cyc + LAT;
    s.v   = v;
    sq.push_back(s);
    if (m_count < DEPTH) begin
      m_mem[m_count] = v;
      m_disp  = v;
      m_rd    = m_count[2:0];
      m_count = m_count + 1;
    end else begin
      m_ovf = 1'b1;
    end
    e.due  = cyc + LAT + 1;
    e.disp = m_disp;
    e.cnt  = m_count[3:0];
    e.rd   = m_rd;
    e.full = (m_count == DEPTH);
    e.ovf  = m_ovf;
    exq.push_back(e);
    tick();
    capture_pulse = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exq.size() > 0; i++) tick();
    if (exq.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout pending=%0d exp=0", exq.size());
      exq.delete();
    end
  endtask

  task automatic review();
    review_pulse = 1'b1;
    if (m_count != 0) begin
      m_rd   = (int'(m_rd) == m_count - 1) ? 3'd0 : m_rd + 3'd1;
      m_disp = m_mem[m_rd];
    end
    tick();
    review_pulse = 1'b0;
    total++;
    if (disp_data !== m_disp) begin
      bad++; $display("FAIL review_disp got=%h exp=%h", disp_data, m_disp);
    end
    total++;
    if (rd_idx !== m_rd) begin
      bad++; $display("FAIL review_rd_idx got=%0d exp=%0d", rd_idx, m_rd);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sq.delete();
    exq.delete();
    m_disp  = '0;
    m_count = 0;
    m_rd    = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    total++;
    if ({disp_data, rd_idx, count, full, overflow} !== '0) begin
      bad++;
      $display("FAIL %s got disp=%h rd=%0d cnt=%0d full=%b ovf=%b exp all zero",
               tag, disp_data, rd_idx, count, full, overflow);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle("reset_state");
  endtask

  task automatic test_single();
    do_reset();
    capture(32'h6ba37d9f);
    drain();
  endtask

  task automatic test_burst3();
    do_reset();
    capture(32'h6ba37d9f);
    capture(32'h6ac49214);
    capture(32'h3f800000);
    drain();
  endtask

  task automatic test_review_wrap();
    for (int i = 0; i < 4; i++) review();
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) capture(32'h40000000 + 32'(i * 32'h1111));
    drain();
    for (int i = 0; i < 3; i++) review();
  endtask

  task automatic test_collision();
    do_reset();
    review();
    total++;
    if (count !== 4'd0) begin
      bad++; $display("FAIL empty_review_count got=%0d exp=0", count);
    end
    capture(32'hc0490fdb);
    drain();
    capture(32'h3eaaaaab);
    for (int i = 0; i < LAT - 1; i++) tick();
    review_pulse = 1'b1;
    tick();
    review_pulse = 1'b0;
    tick();
    total++;
    if (disp_data !== 32'h3eaaaaab || rd_idx !== 3'd1) begin
      bad++;
      $display("FAIL collision_hold got disp=%h rd=%0d exp disp=3eaaaaab rd=1", disp_data, rd_idx);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    capture_pulse = 1'b1;
    tick();
    capture_pulse = 1'b0;
    tick();
    rst = 1'b1;
    capture_pulse = 1'b1;
    tick();
    rst = 1'b0;
    capture_pulse = 1'b0;
    for (int i = 0; i < LAT + 3; i++) tick();
    check_idle("reset_inflight");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst3();
    test_review_wrap();
    test_fill_overflow();
    test_collision();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fp_result_capture.md
Name: fp_result_capture

Overview:
- Write-side counterpart to the operand DataMemory in the FP-adder board system.
- DataMemory reads operand pairs out on each debounced button press. This block writes the resulting adder outputs into a small result buffer.
- Each capture is delayed by the operand-fetch plus adder pipeline latency, so the result matches the press that launched it.
- A second debounced button steps through the stored results; disp_data drives the LEDs and seven-segment displays in place of the raw adder output.

Parameters:
- LATENCY, 4, cycles from capture_pulse high to the matching result valid on result_in (DataMemory register plus fpadd_pipelined stages); legal range 1..15.
- DEPTH, 8, number of result entries; power of two, at least 2.
- FP_WIDTH, 32, width of a single-precision word.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- capture_pulse  in  1  one-cycle pulse from button_control, the same pulse that advances DataMemory.
- review_pulse  in  1  one-cycle pulse from a second button_control instance.
- result_in  in  FP_WIDTH  fpadd_pipelined output.
- disp_data  out  FP_WIDTH  currently selected result.
- rd_idx  out  $clog2(DEPTH)  index of the entry shown on disp_data.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- full  out  1  high when count equals DEPTH.
- overflow  out  1  sticky; set when a result is dropped because the buffer is full.

Behaviour:
- Reset, synchronous and active-high:
  - disp_data=0, rd_idx=0, count=0, full=0, overflow=0.
  - Delay line cleared; memory contents are don't-care.
  - Any capture still in flight is discarded, including one whose pulse falls in the reset cycle.
- Delay line:
  - tag[0] <= capture_pulse; tag[i] <= tag[i-1].
  - Write strobe wr = tag[LATENCY-1], so wr is high exactly LATENCY cycles after the pulse cycle.
  - Overlapping pulses are tracked independently, one per cycle.
- Write, when wr is high and count < DEPTH:
  - mem[count] <= result_in; count <= count+1.
  - rd_idx <= count, i.e. the newest entry; disp_data <= result_in.
  - The new value is visible on disp_data in cycle pulse+LATENCY+1.
- Write, when wr is high and count == DEPTH:
  - No write; overflow <= 1.
  - disp_data, rd_idx and count are unchanged.
- full is combinational from count, or registered alongside it, with the same timing as count.
- Review, when review_pulse is high and wr is low:
  - If count == 0: ignored.
  - Otherwise rd_idx <= (rd_idx == count-1) ? 0 : rd_idx+1, and disp_data <= mem[next rd_idx].
  - Updates one cycle after the pulse; wraps within the stored entries only.
- If wr and review_pulse are high in the same cycle, the write takes priority and the review pulse is dropped.
- overflow clears only on rst.
- Memory: DEPTH x FP_WIDTH register array with a synchronous write and a registered read path into disp_data; no combinational path from input to output.

Decomposition:
- Shared package fpadd_pkg: FP_WIDTH constant, default LATENCY constant (kept in one place so DataMemory, adder and capture stay consistent), and a helper function for index width.
- One natural sub-module, pulse_delay_line: a LATENCY-deep one-bit shift register with synchronous reset that outputs wr.
- Buffer, pointers and flags stay in the top of this block.

Test Plan:
1. Reset, then one capture_pulse with result_in=6ba37d9f held from cycle 4 onward -> at cycle 5 disp_data=6ba37d9f, count=1, rd_idx=0, full=0.
2. Three pulses on consecutive cycles, with result_in sequencing 6ba37d9f, 6ac49214, 3f800000 at the write strobes -> mem[0..2] hold those values, count=3, rd_idx=2, disp_data=3f800000.
3. After scenario 2, apply 4 review pulses -> disp_data goes 6ba37d9f, 6ac49214, 3f800000, 6ba37d9f and rd_idx goes 0, 1, 2, 0.
4. Apply 9 captures with DEPTH=8 -> after the 8th, full=1 and count=8. At the 9th strobe overflow=1, and disp_data and count are unchanged.
5. review_pulse in the same cycle as a write strobe -> the new result is displayed, rd_idx equals the newest index, and no advance occurs. A review_pulse with count=0 -> no change.
6. Assert rst two cycles after a capture_pulse -> nothing is written at the old strobe time, count=0, and all outputs are 0.
